alu_op_sequencer: RTL and testbench

- Issuing side of the ALU interface: accepts one operation request per valid/ready handshake, drives the ALU operands and FunSel, samples ALUOut and the ALU flags, and returns a result with a condition-code verdict.
- Owns the architectural flag register (Z C N O).
- Implements add-with-carry as one or two ALU passes using the stored carry.
- Sits between the control unit and the ALU.

---
 rtl/alu_op_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issues one request to the ALU per valid/ready handshake. ADC is split into
// ADD plus an optional +1 pass driven by the stored carry. Owns FlagReg {Z,C,N,O}.
module alu_op_sequencer #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic [4:0]        ReqFunSel,
   input  logic [DATA_W-1:0] ReqA,
   input  logic [DATA_W-1:0] ReqB,
   input  logic              ReqWF,
   input  logic [2:0]        ReqCond,
   output logic [DATA_W-1:0] AluA,
   output logic [DATA_W-1:0] AluB,
   output logic [4:0]        AluFunSel,
   output logic              AluWF,
   input  logic [DATA_W-1:0] AluOut,
   input  logic [3:0]        AluFlags,
   output logic              RespValid,
   input  logic              RespReady,
   output logic [DATA_W-1:0] RespData,
   output logic [3:0]        RespFlags,
   output logic              RespCondTrue,
   output logic [3:0]        FlagReg
);

   typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

   state_t            state_q;
   logic [4:0]        fs_q;
   logic              wf_q;
   logic [2:0]        cond_q;
   logic [3:0]        f1_q;
   logic [DATA_W-1:0] alu_a_q;
   logic [DATA_W-1:0] alu_b_q;
   logic [4:0]        alu_fs_q;
   logic              alu_wf_q;
   logic              resp_valid_q;
   logic [DATA_W-1:0] resp_data_q;
   logic [3:0]        resp_flags_q;
   logic              resp_cond_q;
   logic [3:0]        flag_q;

   logic [4:0]        req_fs_d;
   logic [4:0]        add_fs_d;
   logic              two_pass_d;
   logic              finish_d;
   logic [3:0]        fin_flags_d;
   logic              fin_cond_d;

   function automatic logic cond_eval(input logic [2:0] c, input logic [3:0] f);
      case (c)
         3'b000:  return 1'b1;
         3'b001:  return f[3];
         3'b010:  return ~f[3];
         3'b011:  return f[2];
         3'b100:  return ~f[2];
         3'b101:  return f[1];
         3'b110:  return ~f[1];
         default: return f[0];
      endcase
   endfunction

   always_comb begin
      req_fs_d    = (ReqFunSel[3:0] == 4'b0101) ? {ReqFunSel[4], 4'b0100} : ReqFunSel;
      add_fs_d    = {fs_q[4], 4'b0100};
      two_pass_d  = (fs_q[3:0] == 4'b0101) && flag_q[2];
      finish_d    = ((state_q == PASS1) && !two_pass_d) || (state_q == PASS2);
      // Second pass: carries from either pass propagate, overflow toggles.
      fin_flags_d = (state_q == PASS2) ?
                    {AluFlags[3], f1_q[2] | AluFlags[2], AluFlags[1], f1_q[0] ^ AluFlags[0]} :
                    AluFlags;
      fin_cond_d  = cond_eval(cond_q, fin_flags_d);
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q      <= IDLE;
         fs_q         <= '0;
         wf_q         <= 1'b0;
         cond_q       <= '0;
         f1_q         <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_fs_q     <= '0;
         alu_wf_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_flags_q <= '0;
         resp_cond_q  <= 1'b0;
         flag_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ReqValid) begin
                  fs_q     <= ReqFunSel;
                  wf_q     <= ReqWF;
                  cond_q   <= ReqCond;
                  alu_a_q  <= ReqA;
                  alu_b_q  <= ReqB;
                  alu_fs_q <= req_fs_d;
                  alu_wf_q <= 1'b1;
                  state_q  <= PASS1;
               end
            end
            PASS1: begin
               f1_q <= AluFlags;
               if (two_pass_d) begin
                  alu_a_q  <= AluOut;
                  alu_b_q  <= DATA_W'(1);
                  alu_fs_q <= add_fs_d;
                  state_q  <= PASS2;
               end
            end
            RESP: begin
               if (RespReady) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: ;
         endcase

         // Completion is shared by single-pass PASS1 and PASS2.
         if (finish_d) begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_fs_q     <= '0;
            alu_wf_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= AluOut;
            resp_flags_q <= fin_flags_d;
            resp_cond_q  <= fin_cond_d;
            if (wf_q) flag_q <= fin_flags_d;
            state_q      <= RESP;
         end
      end
   end

   assign ReqReady     = Reset && (state_q == IDLE);
   assign AluA         = alu_a_q;
   assign AluB         = alu_b_q;
   assign AluFunSel    = alu_fs_q;
   assign AluWF        = alu_wf_q;
   assign RespValid    = resp_valid_q;
   assign RespData     = resp_data_q;
   assign RespFlags    = resp_flags_q;
   assign RespCondTrue = resp_cond_q;
   assign FlagReg      = flag_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: behavioural ALU responder, a
// request-level reference model feeding a queue, and a negedge monitor.
module tb_alu_op_sequencer;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        ReqValid = 1'b0;
   logic        ReqReady;
   logic [4:0]  ReqFunSel = '0;
   logic [31:0] ReqA = '0;
   logic [31:0] ReqB = '0;
   logic        ReqWF = 1'b0;
   logic [2:0]  ReqCond = '0;
   logic [31:0] AluA, AluB, AluOut;
   logic [4:0]  AluFunSel;
   logic        AluWF;
   logic [3:0]  AluFlags;
   logic        RespValid;
   logic        RespReady = 1'b1;
   logic [31:0] RespData;
   logic [3:0]  RespFlags;
   logic        RespCondTrue;
   logic [3:0]  FlagReg;

   alu_op_sequencer #(.DATA_W(32)) dut (
      .Clock(Clock), .Reset(Reset),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqFunSel(ReqFunSel),
      .ReqA(ReqA), .ReqB(ReqB), .ReqWF(ReqWF), .ReqCond(ReqCond),
      .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
      .AluOut(AluOut), .AluFlags(AluFlags),
      .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
      .RespFlags(RespFlags), .RespCondTrue(RespCondTrue), .FlagReg(FlagReg)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  flags;
      logic        cond;
      logic [3:0]  freg;
      int unsigned npass;
      logic [4:0]  fs1;
      logic [31:0] a1;
      int unsigned acc;
   } exp_t;

   exp_t        sb[$];
   exp_t        cur;
   int unsigned checks = 0;
   int unsigned failures = 0;
   int unsigned cyc = 0;
   logic [3:0]  ref_flags = '0;
   int          rr_mode = 0;
   logic        in_resp = 1'b0;
   int unsigned npass_seen = 0;

   // Behavioural ALU: bit4 selects 32-bit (1) or 16-bit (0) width; returns {Z,C,N,O,result}.
   function automatic logic [35:0] alu_f(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b);
      longint unsigned mask, am, bm, s, r;
      int unsigned w;
      logic c, n, o, z, sa, sbb, sr;
      w    = fs[4] ? 32 : 16;
      mask = (64'd1 << w) - 1;
      am   = longint'(a) & mask;
      bm   = longint'(b) & mask;
      sa   = ((am >> (w - 1)) & 1) != 0;
      sbb  = ((bm >> (w - 1)) & 1) != 0;
      c = 1'b0; o = 1'b0; r = 0;
      case (fs[3:0])
         4'b0100: begin
            s = am + bm; r = s & mask; c = ((s >> w) & 1) != 0;
            sr = ((r >> (w - 1)) & 1) != 0; o = (sa == sbb) && (sr != sa);
         end
         4'b0110: begin
            s = am + ((~bm) & mask) + 1; r = s & mask; c = ((s >> w) & 1) != 0;
            sr = ((r >> (w - 1)) & 1) != 0; o = (sa != sbb) && (sr != sa);
         end
         4'b0111: r = am & bm;
         4'b1011: begin s = am << 1; r = s & mask; c = sa; end
         default: r = 0;
      endcase
      z = (r == 0);
      n = ((r >> (w - 1)) & 1) != 0;
      return {z, c, n, o, r[31:0]};
   endfunction

   function automatic logic cond_truth(input logic [2:0] c, input logic [3:0] f);
      logic z, cy, n, o;
      {z, cy, n, o} = f;
      case (c)
         3'd0: return 1'b1;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return cy;
         3'd4: return !cy;
         3'd5: return n;
         3'd6: return !n;
         default: return o;
      endcase
   endfunction

   always_comb {AluFlags, AluOut} = alu_f(AluFunSel, AluA, AluB);

   always @(posedge Clock) cyc <= cyc + 1;

   always @(negedge Clock) begin
      case (rr_mode)
         1:       RespReady = ($urandom_range(0, 9) < 7);
         2:       RespReady = 1'b0;
         default: RespReady = 1'b1;
      endcase
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard when a response first appears, then holds it.
   always @(negedge Clock) begin
      if (!Reset) begin
         in_resp    = 1'b0;
         npass_seen = 0;
      end else begin
         if (AluWF) begin
            npass_seen++;
            chk("alu_never_adc", {63'd0, AluFunSel[3:0] == 4'b0101}, 64'd0);
            if (npass_seen == 1 && sb.size() > 0) begin
               chk("pass1_funsel", 64'(AluFunSel), 64'(sb[0].fs1));
               chk("pass1_a", 64'(AluA), 64'(sb[0].a1));
            end
            if (npass_seen == 2 && sb.size() > 0) begin
               chk("pass2_b", 64'(AluB), 64'd1);
               chk("pass2_funsel", 64'(AluFunSel), 64'(sb[0].fs1));
            end
         end
         if (RespValid) begin
            if (!in_resp) begin
               in_resp = 1'b1;
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_resp actual=%0h expected=none", RespData);
               end else begin
                  cur = sb.pop_front();
                  chk("resp_data", 64'(RespData), 64'(cur.data));
                  chk("resp_flags", 64'(RespFlags), 64'(cur.flags));
                  chk("resp_cond", 64'(RespCondTrue), 64'(cur.cond));
                  chk("flag_reg", 64'(FlagReg), 64'(cur.freg));
                  chk("latency", 64'(cyc - cur.acc), 64'(cur.npass + 1));
                  chk("pass_count", 64'(npass_seen), 64'(cur.npass));
               end
               npass_seen = 0;
            end else begin
               chk("hold_data", 64'(RespData), 64'(cur.data));
               chk("hold_flags", 64'(RespFlags), 64'(cur.flags));
               chk("hold_cond", 64'(RespCondTrue), 64'(cur.cond));
            end
            chk("reqready_busy", 64'(ReqReady), 64'd0);
         end else begin
            in_resp = 1'b0;
         end
      end
   end

   task automatic issue(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                        input logic wf, input logic [2:0] cond);
      exp_t        e;
      logic [35:0] p1, p2;
      logic [4:0]  add_fs;
      int unsigned n;
      @(negedge Clock);
      ReqValid = 1'b1; ReqFunSel = fs; ReqA = a; ReqB = b; ReqWF = wf; ReqCond = cond;
      n = 0;
      while (!ReqReady && n < 60) begin
         @(negedge Clock);
         n++;
      end
      if (!ReqReady) begin
         checks++; failures++;
         $display("FAIL accept_timeout actual=busy expected=ReqReady");
         ReqValid = 1'b0;
         return;
      end
      add_fs = {fs[4], 4'b0100};
      e.fs1  = (fs[3:0] == 4'b0101) ? add_fs : fs;
      e.a1   = a;
      p1     = alu_f(e.fs1, a, b);
      if (fs[3:0] == 4'b0101 && ref_flags[2]) begin
         p2      = alu_f(add_fs, p1[31:0], 32'd1);
         e.data  = p2[31:0];
         e.flags = {p2[35], p1[34] | p2[34], p2[33], p1[32] ^ p2[32]};
         e.npass = 2;
      end else begin
         e.data  = p1[31:0];
         e.flags = p1[35:32];
         e.npass = 1;
      end
      e.cond = cond_truth(cond, e.flags);
      if (wf) ref_flags = e.flags;
      e.freg = ref_flags;
      e.acc  = cyc;
      sb.push_back(e);
      @(negedge Clock);
      ReqValid = 1'b0;
   endtask

   task automatic wait_done();
      int unsigned n;
      n = 0;
      while ((sb.size() != 0 || RespValid) && n < 80) begin
         @(negedge Clock);
         n++;
      end
      if (sb.size() != 0 || RespValid) begin
         checks++; failures++;
         $display("FAIL resp_timeout actual=pending expected=done");
      end
      #1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h7FFF_FFFF;
         4: return 32'h8000_0000;
         5: return 32'h0000_FFFF;
         default: return $urandom;
      endcase
   endfunction

   logic [4:0] fs_tab [9] = '{5'b10100, 5'b00100, 5'b10101, 5'b00101, 5'b10110,
                              5'b00110, 5'b10111, 5'b11011, 5'b01011};

   initial begin
      #1 Reset = 1'b0;
      #3;
      chk("rst_wide", 64'(AluA | AluB | RespData), 64'd0);
      chk("rst_narrow", 64'({ReqReady, AluFunSel, AluWF, RespValid, RespFlags, RespCondTrue, FlagReg}), 64'd0);
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      #1 chk("ready_after_rst", 64'(ReqReady), 64'd1);

      issue(5'b10100, 32'h7FFF_FFFF, 32'd1, 1'b1, 3'b101);
      wait_done();
      chk("add_ovf_data", 64'(RespData), 64'h8000_0000);
      chk("add_ovf_flags", 64'(RespFlags), 64'b0011);
      chk("add_ovf_cond", 64'(RespCondTrue), 64'd1);
      chk("add_ovf_freg", 64'(FlagReg), 64'b0011);

      issue(5'b10110, 32'd3, 32'd3, 1'b0, 3'b001);
      wait_done();
      chk("cmp_data", 64'(RespData), 64'd0);
      chk("cmp_z", 64'(RespFlags[3]), 64'd1);
      chk("cmp_cond", 64'(RespCondTrue), 64'd1);
      chk("cmp_freg_kept", 64'(FlagReg), 64'b0011);

      issue(5'b11011, 32'h8000_0000, 32'd0, 1'b1, 3'b000);
      wait_done();
      chk("lsl_data", 64'(RespData), 64'd0);
      chk("lsl_freg", 64'(FlagReg), 64'b1100);

      issue(5'b10101, 32'd5, 32'd6, 1'b0, 3'b000);
      wait_done();
      chk("adc2_data", 64'(RespData), 64'd12);
      chk("adc2_flags", 64'(RespFlags), 64'b0000);

      issue(5'b10101, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b000);
      wait_done();
      chk("adc_merge_data", 64'(RespData), 64'd0);
      chk("adc_merge_flags", 64'(RespFlags), 64'b1100);

      issue(5'b10100, 32'd1, 32'd1, 1'b1, 3'b000);
      wait_done();
      chk("clear_freg", 64'(FlagReg), 64'b0000);

      issue(5'b10101, 32'd2, 32'd3, 1'b1, 3'b000);
      wait_done();
      chk("adc1_data", 64'(RespData), 64'd5);

      // Backpressure with a stray request that must be dropped.
      rr_mode = 2;
      issue(5'b10100, 32'd10, 32'd20, 1'b1, 3'b000);
      for (int n = 0; n < 10 && !RespValid; n++) @(negedge Clock);
      chk("bp_valid", 64'(RespValid), 64'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         if (i == 1) begin
            ReqValid = 1'b1; ReqFunSel = 5'b10100; ReqA = 32'd99; ReqB = 32'd1; ReqWF = 1'b1;
         end
         if (i == 2) ReqValid = 1'b0;
         chk("bp_hold_valid", 64'(RespValid), 64'd1);
         chk("bp_hold_data", 64'(RespData), 64'd30);
         chk("bp_ready_low", 64'(ReqReady), 64'd0);
      end
      #1 rr_mode = 0;
      @(negedge Clock);
      @(negedge Clock);
      #1;
      chk("bp_released_valid", 64'(RespValid), 64'd0);
      chk("bp_released_ready", 64'(ReqReady), 64'd1);
      chk("bp_data_retained", 64'(RespData), 64'd30);
      chk("bp_flags_retained", 64'(RespFlags), 64'b0000);
      repeat (3) @(negedge Clock);
      chk("bp_no_stray", 64'(sb.size() + 32'(RespValid)), 64'd0);

      rr_mode = 1;
      for (int i = 0; i < 300; i++)
         issue(fs_tab[$urandom_range(0, 8)], pick(), pick(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      rr_mode = 0;
      wait_done();

      // Reset while the +1 pass of an ADC is on the ALU.
      issue(5'b11011, 32'h8000_0000, 32'd0, 1'b1, 3'b000);
      wait_done();
      issue(5'b10101, 32'd100, 32'd200, 1'b1, 3'b000);
      @(negedge Clock);
      chk("in_pass2", 64'({AluWF, AluB}), {31'd0, 1'b1, 32'd1});
      #2 Reset = 1'b0;
      #1;
      chk("midrst_wide", 64'(AluA | AluB | RespData), 64'd0);
      chk("midrst_narrow", 64'({ReqReady, AluFunSel, AluWF, RespValid, RespFlags, RespCondTrue, FlagReg}), 64'd0);
      sb.delete();
      ref_flags = '0;
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      #1 chk("midrst_ready", 64'(ReqReady), 64'd1);
      issue(5'b10101, 32'd2, 32'd3, 1'b1, 3'b000);
      wait_done();
      chk("post_rst_adc", 64'(RespData), 64'd5);
      chk("post_rst_freg", 64'(FlagReg), 64'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
